// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, ALUOp encodings and control-bundle bit positions.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  // id_ctrl = {RegDst, jump, MemRead, MemWrite, ALUSrc, ALUOp[1:0], MemtoReg, RegWrite}
  localparam int IDC_W        = 9;
  localparam int IDC_REGDST   = 8;
  localparam int IDC_JUMP     = 7;
  localparam int IDC_MEMREAD  = 6;
  localparam int IDC_MEMWRITE = 5;
  localparam int IDC_ALUSRC   = 4;
  localparam int IDC_ALUOP_LO = 2;
  localparam int IDC_MEMTOREG = 1;
  localparam int IDC_REGWRITE = 0;

  // ex_ctrl is the low seven bits of id_ctrl, same positions
  localparam int EXC_W        = 7;
  localparam int EXC_MEMREAD  = 6;
  localparam int EXC_MEMWRITE = 5;
  localparam int EXC_REGWRITE = 0;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_to_reg;
    logic       reg_write;
  } ex_ctrl_t;

  function automatic logic op_uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detect, purely combinational; rt dependence is decoded from
// the raw opcode so there is no path through the main control unit.
module hazard_detect
  import mips_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              id_valid,
  input  logic [5:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_wreg,
  output logic              load_use
);

  logic rs_match;
  logic rt_match;
  logic ex_load;

  assign ex_load  = ex_valid & ex_mem_read & (ex_wreg != '0);
  assign rs_match = (ex_wreg == id_rs);
  assign rt_match = op_uses_rt(id_opcode) & (ex_wreg == id_rt);
  assign load_use = id_valid & ex_load & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register, 1-cycle latency; flush > ex_hold (freeze) > load-use bubble > capture.
// stall = load_use | ex_hold. Optional bubble counter under ID_EX_STALL_CNT_EN.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [5:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [8:0]        id_ctrl,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              stall,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_wreg,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [6:0]        ex_ctrl,
  output logic [15:0]       stall_count
);

  logic              ex_valid_q,   ex_valid_d;
  ex_ctrl_t          ex_ctrl_q,    ex_ctrl_d;
  logic [REG_AW-1:0] ex_rs_q,      ex_rs_d;
  logic [REG_AW-1:0] ex_wreg_q,    ex_wreg_d;
  logic [DATA_W-1:0] ex_rs_data_q, ex_rs_data_d;
  logic [DATA_W-1:0] ex_rt_data_q, ex_rt_data_d;
  logic [DATA_W-1:0] ex_imm_q,     ex_imm_d;
  logic              load_use;
  logic              bubble_cnt_en;
  logic              unused_jump;

  // the jump bit is consumed by IF redirect logic, never by EX
  assign unused_jump = id_ctrl[IDC_JUMP];

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .id_valid    (id_valid),
    .id_opcode   (id_opcode),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_valid    (ex_valid_q),
    .ex_mem_read (ex_ctrl_q.mem_read),
    .ex_wreg     (ex_wreg_q),
    .load_use    (load_use)
  );

  assign stall         = load_use | ex_hold;
  assign bubble_cnt_en = load_use & ~flush & ~ex_hold;

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_ctrl_d    = ex_ctrl_q;
    ex_rs_d      = ex_rs_q;
    ex_wreg_d    = ex_wreg_q;
    ex_rs_data_d = ex_rs_data_q;
    ex_rt_data_d = ex_rt_data_q;
    ex_imm_d     = ex_imm_q;
    if (flush || (!ex_hold && (load_use || !id_valid))) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
    end else if (!ex_hold) begin
      ex_valid_d   = 1'b1;
      ex_ctrl_d    = ex_ctrl_t'(id_ctrl[IDC_MEMREAD:IDC_REGWRITE]);
      ex_rs_d      = id_rs;
      ex_wreg_d    = id_ctrl[IDC_REGDST] ? id_rd : id_rt;
      ex_rs_data_d = id_rs_data;
      ex_rt_data_d = id_rt_data;
      ex_imm_d     = id_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_ctrl_q    <= '0;
      ex_rs_q      <= '0;
      ex_wreg_q    <= '0;
      ex_rs_data_q <= '0;
      ex_rt_data_q <= '0;
      ex_imm_q     <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_rs_q      <= ex_rs_d;
      ex_wreg_q    <= ex_wreg_d;
      ex_rs_data_q <= ex_rs_data_d;
      ex_rt_data_q <= ex_rt_data_d;
      ex_imm_q     <= ex_imm_d;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bubble_cnt_en && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  logic unused_cnt_en;
  assign unused_cnt_en = bubble_cnt_en;
  assign stall_count   = 16'h0000;
`endif

  assign ex_valid   = ex_valid_q;
  assign ex_ctrl    = ex_ctrl_q;
  assign ex_rs      = ex_rs_q;
  assign ex_wreg    = ex_wreg_q;
  assign ex_rs_data = ex_rs_data_q;
  assign ex_rt_data = ex_rt_data_q;
  assign ex_imm     = ex_imm_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard scenarios plus random traffic vs. a behavioural model.
module tb_id_ex_stage;
  import mips_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [5:0]    id_opcode = '0;
  logic [AW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic [DW-1:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0;
  logic [8:0]    id_ctrl = '0;
  logic          flush = 1'b0, ex_hold = 1'b0;
  logic          stall, ex_valid;
  logic [AW-1:0] ex_rs, ex_wreg;
  logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [6:0]    ex_ctrl;
  logic [15:0]   stall_count;

  id_ex_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_ctrl(id_ctrl), .flush(flush),
    .ex_hold(ex_hold), .stall(stall), .ex_valid(ex_valid), .ex_rs(ex_rs),
    .ex_wreg(ex_wreg), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          vld;
    logic [5:0]    op;
    logic [AW-1:0] rs, rt, rd;
    logic [DW-1:0] rsd, rtd, imm;
    logic [8:0]    ctrl;
    logic          flush, hold, rst;
  } stim_t;

  typedef struct packed {
    logic          valid;
    logic [6:0]    ctrl;
    logic [AW-1:0] rs, wreg;
    logic [DW-1:0] rsd, rtd, imm;
    logic [15:0]   cnt;
  } ex_t;

  typedef struct packed {
    logic stall;
    ex_t  st;
  } exp_t;

  exp_t q[$];
  ex_t  m = '0;
  int   tests = 0;
  int   fails = 0;

  function automatic ex_t dut_state();
    return {ex_valid, ex_ctrl, ex_rs, ex_wreg, ex_rs_data, ex_rt_data, ex_imm, stall_count};
  endfunction

  // An instruction needs rt as a source only for R-type and sw; a load in EX
  // writing a nonzero register that ID reads forces one bubble.
  function automatic logic model_hazard(input ex_t st, input stim_t s);
    logic reads_rt;
    reads_rt = (s.op == OP_RTYPE) || (s.op == OP_SW);
    return s.vld && st.valid && st.ctrl[EXC_MEMREAD] && (st.wreg != 0) &&
           ((st.wreg == s.rs) || (reads_rt && (st.wreg == s.rt)));
  endfunction

  function automatic stim_t mk(input logic [5:0] op, input logic [AW-1:0] rs, rt, rd);
    stim_t s;
    s = '0;
    s.vld = 1'b1; s.op = op; s.rs = rs; s.rt = rt; s.rd = rd;
    s.rsd = $urandom; s.rtd = $urandom; s.imm = $urandom;
    case (op)
      OP_LW: begin
        s.ctrl[IDC_MEMREAD] = 1'b1; s.ctrl[IDC_ALUSRC] = 1'b1; s.ctrl[IDC_MEMTOREG] = 1'b1;
        s.ctrl[IDC_REGWRITE] = 1'b1; s.ctrl[IDC_ALUOP_LO +: 2] = ALUOP_ADD;
      end
      OP_SW: begin
        s.ctrl[IDC_MEMWRITE] = 1'b1; s.ctrl[IDC_ALUSRC] = 1'b1; s.ctrl[IDC_ALUOP_LO +: 2] = ALUOP_ADD;
      end
      OP_RTYPE: begin
        s.ctrl[IDC_REGDST] = 1'b1; s.ctrl[IDC_REGWRITE] = 1'b1; s.ctrl[IDC_ALUOP_LO +: 2] = ALUOP_FUNCT;
      end
      OP_ANDI: begin
        s.ctrl[IDC_ALUSRC] = 1'b1; s.ctrl[IDC_REGWRITE] = 1'b1; s.ctrl[IDC_ALUOP_LO +: 2] = ALUOP_AND;
      end
      OP_J: s.ctrl[IDC_JUMP] = 1'b1;
      default: s.ctrl[IDC_ALUOP_LO +: 2] = ALUOP_SUB;
    endcase
    return s;
  endfunction

  task automatic check_zero(input string name);
    tests++;
    if (dut_state() != '0 || stall !== 1'b0) begin
      fails++;
      $display("FAIL %s: got state=%h stall=%b, want all zero", name, dut_state(), stall);
    end
  endtask

  task automatic issue(input stim_t s);
    exp_t e;
    ex_t  n;
    logic hz;
    @(negedge clk);
    rst_n = 1'b1;
    id_valid = s.vld; id_opcode = s.op; id_rs = s.rs; id_rt = s.rt; id_rd = s.rd;
    id_rs_data = s.rsd; id_rt_data = s.rtd; id_imm = s.imm; id_ctrl = s.ctrl;
    flush = s.flush; ex_hold = s.hold;
    hz = model_hazard(m, s);
    e.stall = hz | s.hold;
    n = m;
    if (s.rst) begin
      n = '0;
    end else if (s.flush || (!s.hold && (hz || !s.vld))) begin
      n.valid = 1'b0;
      n.ctrl  = '0;
`ifdef ID_EX_STALL_CNT_EN
      if (!s.flush && hz && m.cnt != 16'hFFFF) n.cnt = m.cnt + 16'd1;
`endif
    end else if (!s.hold) begin
      n.valid = 1'b1;
      n.ctrl  = s.ctrl[6:0];
      n.rs    = s.rs;
      n.wreg  = s.ctrl[IDC_REGDST] ? s.rd : s.rt;
      n.rsd   = s.rsd; n.rtd = s.rtd; n.imm = s.imm;
    end
    e.st = n;
    q.push_back(e);
    m = n;
    if (s.rst) begin
      #3 rst_n = 1'b0;
      #1 check_zero("reset_mid_stall");
    end
  endtask

  // Monitor: stall is checked mid-cycle, EX state just after the following edge.
  initial begin
    exp_t e;
    ex_t  got;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (stall !== e.stall) begin
          fails++;
          $display("FAIL stall t=%0t got=%b want=%b", $time, stall, e.stall);
        end
        @(posedge clk);
        #1;
        got = dut_state();
        tests++;
        if (got !== e.st) begin
          fails++;
          $display("FAIL ex_state t=%0t got v=%b ctrl=%h rs=%0d wreg=%0d rsd=%h rtd=%h imm=%h cnt=%0d want v=%b ctrl=%h rs=%0d wreg=%0d rsd=%h rtd=%h imm=%h cnt=%0d",
                   $time, got.valid, got.ctrl, got.rs, got.wreg, got.rsd, got.rtd, got.imm, got.cnt,
                   e.st.valid, e.st.ctrl, e.st.rs, e.st.wreg, e.st.rsd, e.st.rtd, e.st.imm, e.st.cnt);
        end
        tests++;
        if (!ex_valid && (ex_ctrl[EXC_MEMWRITE] || ex_ctrl[EXC_REGWRITE])) begin
          fails++;
          $display("FAIL idle_side_effect t=%0t ex_ctrl=%h with ex_valid=0, want MemWrite=RegWrite=0", $time, ex_ctrl);
        end
      end
    end
  end

  initial begin
`ifdef ID_EX_STALL_CNT_EN
    #2_000_000;
`else
    #100_000;
`endif
    $display("FAIL watchdog: bench did not finish, %0d expectations pending", q.size());
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    stim_t s;
    logic [5:0] ops[5];
    ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_RTYPE; ops[3] = OP_ANDI; ops[4] = OP_J;

    #2 check_zero("reset_state");

    // load-use on rs: one bubble then the dependent R-type is captured
    issue(mk(OP_LW, 5'd1, 5'd8, 5'd0));
    issue(mk(OP_RTYPE, 5'd8, 5'd2, 5'd3));
    issue(mk(OP_RTYPE, 5'd8, 5'd2, 5'd3));
    // $0 destination never hazards
    issue(mk(OP_LW, 5'd1, 5'd0, 5'd0));
    issue(mk(OP_RTYPE, 5'd0, 5'd4, 5'd5));
    // andi does not read rt; sw does
    issue(mk(OP_LW, 5'd1, 5'd9, 5'd0));
    issue(mk(OP_ANDI, 5'd3, 5'd9, 5'd0));
    issue(mk(OP_LW, 5'd1, 5'd9, 5'd0));
    issue(mk(OP_SW, 5'd3, 5'd9, 5'd0));
    issue(mk(OP_SW, 5'd3, 5'd9, 5'd0));
    // flush wins over a simultaneous load-use
    issue(mk(OP_LW, 5'd1, 5'd8, 5'd0));
    s = mk(OP_RTYPE, 5'd8, 5'd2, 5'd3); s.flush = 1'b1;
    issue(s);
    // hold freezes a valid sw for three cycles, then ID is captured
    issue(mk(OP_SW, 5'd2, 5'd6, 5'd0));
    s = mk(OP_RTYPE, 5'd4, 5'd5, 5'd7);
    s.hold = 1'b1;
    repeat (3) issue(s);
    s.hold = 1'b0;
    issue(s);
    // reset while a load-use stall is pending
    issue(mk(OP_LW, 5'd1, 5'd8, 5'd0));
    s = mk(OP_RTYPE, 5'd8, 5'd2, 5'd3); s.rst = 1'b1;
    issue(s);

    for (int i = 0; i < 400; i++) begin
      s = mk(ops[$urandom_range(0, 4)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)));
      if ($urandom_range(0, 9) < 3) s.ctrl = 9'($urandom);
      s.vld   = ($urandom_range(0, 99) < 85);
      s.flush = ($urandom_range(0, 99) < 10);
      s.hold  = ($urandom_range(0, 99) < 15);
      issue(s);
    end

`ifdef ID_EX_STALL_CNT_EN
    // every other edge is a load-use bubble; run past the saturation point
    issue(mk(OP_LW, 5'd1, 5'd8, 5'd0));
    for (int i = 0; i < 140_000; i++) issue(mk(OP_LW, 5'd8, 5'd8, 5'd0));
    @(posedge clk);
    #1;
    tests++;
    if (stall_count !== 16'hFFFF) begin
      fails++;
      $display("FAIL stall_count_saturate got=%h want=FFFF", stall_count);
    end
`endif

    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath word width.
REQ-002 SHALL have parameter REG_AW, default 5, register-address width.
REQ-003 SHALL have a single clock; reset is asynchronous, active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 id_valid  in  1  ID holds a valid instruction.
REQ-007 id_opcode  in  6  raw ID opcode, used for hazard decode.
REQ-008 id_rs / id_rt / id_rd  in  REG_AW each  ID register fields.
REQ-009 id_rs_data / id_rt_data / id_imm  in  DATA_W each  register-file reads and sign-extended immediate.
REQ-010 id_ctrl  in  9  main-control bundle {RegDst,jump,MemRead,MemWrite,ALUSrc,ALUOp[1:0],MemtoReg,RegWrite}.
REQ-011 flush  in  1  kill the instruction entering EX (jump/branch redirect).
REQ-012 ex_hold  in  1  downstream wait; freeze the EX register.
REQ-013 stall  out  1  freeze PC/IF-ID and force the main control unit to a bubble.
REQ-014 ex_valid  out  1  EX holds a valid instruction.
REQ-015 ex_rs / ex_wreg  out  REG_AW each  EX source register; destination (RegDst ? rd : rt).
REQ-016 ex_rs_data / ex_rt_data / ex_imm  out  DATA_W each  registered operands.
REQ-017 ex_ctrl  out  7  {MemRead,MemWrite,ALUSrc,ALUOp[1:0],MemtoReg,RegWrite}.
REQ-018 stall_count  out  16  bubble counter (see Configuration).

Function
REQ-019 Pipeline latency SHALL be exactly one clk cycle, ID inputs to ex_* outputs.
REQ-020 load_use SHALL be combinational: id_valid & ex_valid & ex_ctrl.MemRead & ex_wreg!=0 & (ex_wreg==id_rs | (uses_rt & ex_wreg==id_rt)).
REQ-021 uses_rt SHALL be 1 only for id_opcode 6'b000000 (R-type) or 6'b101011 (sw); it SHALL be decoded from id_opcode, never from id_ctrl, so no loop forms through the control unit.
REQ-022 stall SHALL equal load_use | ex_hold.
REQ-023 Per-edge priority SHALL be: flush > ex_hold > load_use > capture.
REQ-024 flush: ex_valid<=0 and ex_ctrl<=0; datapath fields unchanged.
REQ-025 ex_hold without flush: every EX register SHALL keep its value.
REQ-026 load_use, or !id_valid: a bubble is inserted (ex_valid<=0, ex_ctrl<=0); datapath fields unchanged.
REQ-027 capture: all fields SHALL be loaded and ex_valid<=1; ex_wreg SHALL be id_rd if RegDst=1, else id_rt; the jump bit SHALL be dropped.
REQ-028 A load-use stall SHALL last exactly one cycle; the next cycle the bubble makes load_use 0 and the dependent instruction is captured.
REQ-029 ex_ctrl.MemWrite and ex_ctrl.RegWrite SHALL never be 1 while ex_valid=0.

Reset
REQ-030 While rst_n=0, SHALL clear ex_valid, ex_ctrl, ex_rs, ex_wreg, ex_rs_data, ex_rt_data, ex_imm and stall_count to 0 asynchronously.
REQ-031 After reset, stall SHALL be 0 unless ex_hold=1; reset asserted mid-stall SHALL drop the pending bubble.

Configuration
REQ-032 Macro ID_EX_STALL_CNT_EN defined: stall_count SHALL increment by 1 on each edge where a load_use bubble is inserted (flush=0, ex_hold=0), saturating at 16'hFFFF.
REQ-033 Macro ID_EX_STALL_CNT_EN undefined: no counter flops SHALL exist and stall_count SHALL be tied to 16'h0000.

Structure
REQ-034 Package mips_pkg SHALL hold the opcode constants (LW 100011, SW 101011, RTYPE 000000, ANDI 001100, J 000010), the ALUOp encodings, and the id_ctrl/ex_ctrl bit positions.
REQ-035 Hazard logic (REQ-020/021) SHALL be sub-module hazard_detect; the pipeline register stays in id_ex_stage.

Verification
REQ-036 lw $8 captured, then R-type with rs=8 in ID -> stall=1 one cycle, one bubble (ex_valid=0), R-type in EX next cycle, stall_count=1.
REQ-037 lw $0 then R-type with rs=0 -> stall=0, no bubble.
REQ-038 lw $9 then andi with rt=9, rs=3 -> stall=0 (uses_rt=0); sw with rt=9 instead -> stall=1.
REQ-039 flush=1 together with load_use=1 -> ex_valid=0, ex_ctrl=0, stall_count unchanged.
REQ-040 ex_hold=1 for 3 cycles with a valid sw in EX -> ex_* stable, stall=1; the ID instruction is captured on the edge after hold falls.
REQ-041 rst_n low mid-stall -> all outputs 0 immediately; 70000 load-use bubbles with ID_EX_STALL_CNT_EN -> stall_count=16'hFFFF.
